// File: rtl/seq_gen_1011_if.sv
// Handshake + serial-link bundle for the 1011-framed serial transmitter.
// The source side drives data_in/data_valid; the transmitter drives the rest.
interface seq_gen_1011_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              out_bit;
  logic              out_valid;
  logic              stuffed;
  logic              frame_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, out_bit, out_valid, stuffed, frame_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, out_bit, out_valid, stuffed, frame_done
  );
endinterface

// File: rtl/seq_gen_1011.sv
// Serial frame transmitter: 1011 preamble, then MSB-first payload with a zero
// stuffed after every 101 so that 1011 only ever appears as a frame start.
module seq_gen_1011 #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic clk,
  input  logic reset,
  seq_gen_1011_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [3:0] PREAMBLE = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_GAP} state_t;

  // State names the phase of the bit currently on the wire; next-state logic
  // also decides the next registered output bit.
  state_t            state, state_nx;
  logic [DATA_W-1:0] sh, sh_nx;
  logic [2:0]        h, h_nx;
  logic [1:0]        pcnt, pcnt_nx;
  logic [CNT_W-1:0]  rem, rem_nx;
  logic [GAP_W-1:0]  gcnt, gcnt_nx;
  logic              obit_q, oval_q, stf_q, done_q;
  logic              obit_nx, oval_nx, stf_nx, done_nx;
  logic              emit_pay;

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    h_nx     = h;
    pcnt_nx  = pcnt;
    rem_nx   = rem;
    gcnt_nx  = gcnt;
    obit_nx  = 1'b0;
    oval_nx  = 1'b0;
    stf_nx   = 1'b0;
    done_nx  = 1'b0;
    emit_pay = 1'b0;
    case (state)
      S_IDLE: if (bus.data_valid) begin
        state_nx = S_PRE;
        sh_nx    = bus.data_in;
        rem_nx   = CNT_W'(DATA_W);
        pcnt_nx  = 2'd0;
        h_nx     = 3'b001;
        obit_nx  = 1'b1;
        oval_nx  = 1'b1;
      end
      S_PRE: if (pcnt == 2'd3) begin
        state_nx = S_PAY;
        emit_pay = 1'b1;
      end else begin
        pcnt_nx = pcnt + 2'd1;
        obit_nx = PREAMBLE[2'd2 - pcnt];
        oval_nx = 1'b1;
        h_nx    = {h[1:0], PREAMBLE[2'd2 - pcnt]};
      end
      S_PAY: if (rem == '0) begin
        state_nx = (GAP > 0) ? S_GAP : S_IDLE;
        gcnt_nx  = GAP_LAST;
      end else begin
        emit_pay = 1'b1;
      end
      S_GAP: if (gcnt == '0) state_nx = S_IDLE;
             else gcnt_nx = gcnt - GAP_W'(1);
      default: state_nx = S_IDLE;
    endcase

    // Stuffing never consumes a data bit, so a stuff can't trail the last one.
    if (emit_pay) begin
      oval_nx = 1'b1;
      if (h == 3'b101) begin
        stf_nx = 1'b1;
        h_nx   = {h[1:0], 1'b0};
      end else begin
        obit_nx = sh[DATA_W-1];
        sh_nx   = sh << 1;
        rem_nx  = rem - CNT_W'(1);
        done_nx = (rem == CNT_W'(1));
        h_nx    = {h[1:0], sh[DATA_W-1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      sh     <= '0;
      h      <= '0;
      pcnt   <= '0;
      rem    <= '0;
      gcnt   <= '0;
      obit_q <= 1'b0;
      oval_q <= 1'b0;
      stf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      sh     <= sh_nx;
      h      <= h_nx;
      pcnt   <= pcnt_nx;
      rem    <= rem_nx;
      gcnt   <= gcnt_nx;
      obit_q <= obit_nx;
      oval_q <= oval_nx;
      stf_q  <= stf_nx;
      done_q <= done_nx;
    end
  end

  assign bus.data_ready = (state == S_IDLE);
  assign bus.out_bit    = obit_q;
  assign bus.out_valid  = oval_q;
  assign bus.stuffed    = stf_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_seq_gen_1011.sv
// Randomized bench for seq_gen_1011: handshakes push expected per-cycle wire
// activity into a queue; a negedge monitor pops and compares every cycle.
module tb_seq_gen_1011;
  localparam int DATA_W = 8;
  localparam int GAP    = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_gen_1011_if #(.DATA_W(DATA_W)) bus();

  seq_gen_1011 #(.DATA_W(DATA_W), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic vld;
    logic b;
    logic stf;
    logic done;
    logic pre4;
  } exp_t;

  exp_t  expq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    armed = 0;
  int    starts[$];
  int    frames_done = 0;
  int    last_n = 0;
  logic [31:0] last_b = '0, last_s = '0;

  function automatic exp_t mk(logic v, logic b, logic s, logic d, logic p);
    exp_t e;
    e.vld = v; e.b = b; e.stf = s; e.done = d; e.pre4 = p;
    return e;
  endfunction

  // Reference: build the wire as a bit list, inserting a 0 whenever the last
  // three wire bits read 1,0,1 before the next data bit goes out.
  task automatic push_frame(input logic [DATA_W-1:0] w);
    bit wq[$];
    int n;
    wq = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) expq.push_back(mk(1'b1, wq[k], 1'b0, 1'b0, k == 3));
    for (int i = DATA_W - 1; i >= 0; i--) begin
      n = wq.size();
      if (wq[n-3] == 1'b1 && wq[n-2] == 1'b0 && wq[n-1] == 1'b1) begin
        wq.push_back(1'b0);
        expq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      wq.push_back(w[i]);
      expq.push_back(mk(1'b1, w[i], 1'b0, i == 0, 1'b0));
    end
    for (int g = 0; g < GAP; g++) expq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Handshake observer
  initial forever begin
    @(posedge clk);
    if (!reset) expq.delete();
    else if (bus.data_valid && bus.data_ready) push_frame(bus.data_in);
  end

  // Monitor / checker
  initial begin
    exp_t e;
    logic [5:0] got, want;
    logic [3:0] hist;
    logic [31:0] cap_b, cap_s;
    int cap_n;
    bit was_empty, prev_vld;
    hist = '0; cap_b = '0; cap_s = '0; cap_n = 0; prev_vld = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        hist = {hist[2:0], bus.out_bit};
        was_empty = (expq.size() == 0);
        if (was_empty) e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        else e = expq.pop_front();
        want = {e.vld, e.b, e.stf, e.done, was_empty, e.pre4};
        got  = {bus.out_valid, bus.out_bit, bus.stuffed, bus.frame_done,
                bus.data_ready, hist == 4'b1011};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL cycle %0d {valid,bit,stuffed,done,ready,det1011} got=%b exp=%b",
                   cyc, got, want);
        end
        if (bus.out_valid) begin
          if (!prev_vld) begin
            cap_b = '0; cap_s = '0; cap_n = 0;
            starts.push_back(cyc);
          end
          cap_b = {cap_b[30:0], bus.out_bit};
          cap_s = {cap_s[30:0], bus.stuffed};
          cap_n++;
          if (bus.frame_done) begin
            last_b = cap_b; last_s = cap_s; last_n = cap_n;
            frames_done++;
          end
        end
        prev_vld = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] w, input bit hold);
    int k;
    k = 0;
    @(negedge clk);
    bus.data_in = w;
    bus.data_valid = 1'b1;
    while (!bus.data_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout got=ready_low exp=ready_high");
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.data_in = DATA_W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((expq.size() != 0 || !bus.data_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++; failures++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
    @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input int fd0, input int n,
                             input logic [31:0] b, input logic [31:0] s);
    checks++;
    if (frames_done != fd0 + 1 || last_n != n || last_b != b || last_s != s) begin
      failures++;
      $display("FAIL frame_%s got frames=%0d len=%0d bits=%h stf=%h exp frames=%0d len=%0d bits=%h stf=%h",
               nm, frames_done, last_n, last_b, last_s, fd0 + 1, n, b, s);
    end
  endtask

  initial begin
    int fd0, n0, k;
    bus.data_in = '0;
    bus.data_valid = 1'b1;

    // Reset held 3 cycles with data_valid high: no frame may start
    reset = 1'b0;
    @(posedge clk);
    armed = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fd0 = frames_done;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.data_valid = 1'b0;
    wait_idle();
    check_frame("00", fd0, 12, 32'h0000_0B00, 32'h0);

    fd0 = frames_done; send(8'h5A, 0); wait_idle();
    check_frame("5A", fd0, 14, 32'h0000_2D34, 32'h0000_0082);
    fd0 = frames_done; send(8'hAA, 0); wait_idle();
    check_frame("AA", fd0, 14, 32'h0000_2E94, 32'h0000_0042);
    fd0 = frames_done; send(8'hFF, 0); wait_idle();
    check_frame("FF", fd0, 12, 32'h0000_0BFF, 32'h0);

    // Back-to-back with data_valid held: 0x00 then 0xFF
    n0 = starts.size();
    send(8'h00, 1);
    @(negedge clk);
    bus.data_in = 8'hFF;
    k = 0;
    while (starts.size() < n0 + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.data_valid = 1'b0;
    checks++;
    if (starts.size() < n0 + 2 || starts[n0+1] - starts[n0] != 1 + 4 + DATA_W + GAP) begin
      failures++;
      $display("FAIL b2b_period got=%0d exp=%0d",
               (starts.size() >= n0 + 2) ? starts[n0+1] - starts[n0] : -1, 1 + 4 + DATA_W + GAP);
    end
    wait_idle();

    // Randomized words with random idle spacing
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DATA_W'($urandom), 0);
    end
    wait_idle();

    // Reset during payload bit 3 (a stuffed bit for 0x5A)
    fd0 = frames_done;
    send(8'h5A, 0);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (frames_done != fd0) begin
      failures++;
      $display("FAIL reset_abandon frames got=%0d exp=%0d", frames_done, fd0);
    end
    fd0 = frames_done; send(8'h5A, 0); wait_idle();
    check_frame("5A_after_reset", fd0, 14, 32'h0000_2D34, 32'h0000_0082);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
